// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_pkg
// Description : Editor key codes, PS/2 prefixes and scan-code set 2 tables.
// Revision    : 1.0
// ============================================================================
package ps2_kbd_pkg;

    localparam logic [7:0] C_PAGEUP    = 8'h01;
    localparam logic [7:0] C_HOME      = 8'h02;
    localparam logic [7:0] C_END       = 8'h03;
    localparam logic [7:0] C_PAGEDOWN  = 8'h04;
    localparam logic [7:0] C_BACKSPACE = 8'h08;
    localparam logic [7:0] C_TAB       = 8'h09;
    localparam logic [7:0] C_RETURN    = 8'h0D;
    localparam logic [7:0] C_UP        = 8'h11;
    localparam logic [7:0] C_DOWN      = 8'h12;
    localparam logic [7:0] C_LEFT      = 8'h13;
    localparam logic [7:0] C_RIGHT     = 8'h14;
    localparam logic [7:0] C_F1        = 8'h15;
    localparam logic [7:0] C_F2        = 8'h16;
    localparam logic [7:0] C_F3        = 8'h17;
    localparam logic [7:0] C_F4        = 8'h18;
    localparam logic [7:0] C_F5        = 8'h19;
    localparam logic [7:0] C_F6        = 8'h1A;
    localparam logic [7:0] C_F7        = 8'h1B;
    localparam logic [7:0] C_F8        = 8'h1C;
    localparam logic [7:0] C_F9        = 8'h1D;
    localparam logic [7:0] C_F10       = 8'h1E;
    localparam logic [7:0] C_F11       = 8'h1F;
    localparam logic [7:0] C_SPACE     = 8'h20;
    localparam logic [7:0] C_TILDE     = 8'h7E;
    localparam logic [7:0] C_DEL       = 8'h7F;
    localparam logic [7:0] C_DIERESIS  = 8'hA8;
    localparam logic [7:0] C_ACUTE     = 8'hB4;

    localparam logic [7:0] C_PFX_E0    = 8'hE0;
    localparam logic [7:0] C_PFX_E1    = 8'hE1;
    localparam logic [7:0] C_PFX_F0    = 8'hF0;

    localparam logic [7:0] C_SC_LSHIFT = 8'h12;
    localparam logic [7:0] C_SC_RSHIFT = 8'h59;
    localparam logic [7:0] C_SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {DEC_NORM, DEC_EXT, DEC_BRK, DEC_EXTBRK, DEC_SKIP} dec_state_t;

    function automatic logic [7:0] sc_to_normal(input logic [7:0] sc);
        logic [7:0] code;
        code = 8'h00;
        case (sc)
            8'h1C: code = "a";  8'h32: code = "b";  8'h21: code = "c";  8'h23: code = "d";
            8'h24: code = "e";  8'h2B: code = "f";  8'h34: code = "g";  8'h33: code = "h";
            8'h43: code = "i";  8'h3B: code = "j";  8'h42: code = "k";  8'h4B: code = "l";
            8'h3A: code = "m";  8'h31: code = "n";  8'h44: code = "o";  8'h4D: code = "p";
            8'h15: code = "q";  8'h2D: code = "r";  8'h1B: code = "s";  8'h2C: code = "t";
            8'h3C: code = "u";  8'h2A: code = "v";  8'h1D: code = "w";  8'h22: code = "x";
            8'h35: code = "y";  8'h1A: code = "z";
            8'h45: code = "0";  8'h16: code = "1";  8'h1E: code = "2";  8'h26: code = "3";
            8'h25: code = "4";  8'h2E: code = "5";  8'h36: code = "6";  8'h3D: code = "7";
            8'h3E: code = "8";  8'h46: code = "9";
            8'h0E: code = 8'h60; 8'h4E: code = "-";  8'h55: code = "=";  8'h5D: code = 8'h5C;
            8'h54: code = "[";  8'h5B: code = "]";  8'h4C: code = ";";  8'h41: code = ",";
            8'h49: code = ".";  8'h4A: code = "/";  8'h52: code = C_ACUTE;
            8'h66: code = C_BACKSPACE;  8'h0D: code = C_TAB;
            8'h5A: code = C_RETURN;     8'h29: code = C_SPACE;
            8'h05: code = C_F1;  8'h06: code = C_F2;  8'h04: code = C_F3;  8'h0C: code = C_F4;
            8'h03: code = C_F5;  8'h0B: code = C_F6;  8'h83: code = C_F7;  8'h0A: code = C_F8;
            8'h01: code = C_F9;  8'h09: code = C_F10; 8'h78: code = C_F11;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    function automatic logic sc_is_letter(input logic [7:0] sc);
        logic [7:0] n;
        n = sc_to_normal(sc);
        return (n >= "a") && (n <= "z");
    endfunction

    // Keys without a distinct shifted glyph keep their normal code.
    function automatic logic [7:0] sc_to_shifted(input logic [7:0] sc);
        logic [7:0] code;
        code = sc_to_normal(sc);
        if (sc_is_letter(sc)) begin
            code = code - 8'h20;
        end
        case (sc)
            8'h45: code = ")";  8'h16: code = "!";  8'h1E: code = "@";  8'h26: code = "#";
            8'h25: code = "$";  8'h2E: code = "%";  8'h36: code = "^";  8'h3D: code = "&";
            8'h3E: code = "*";  8'h46: code = "(";
            8'h0E: code = C_TILDE;  8'h4E: code = "_";  8'h55: code = "+";  8'h5D: code = "|";
            8'h54: code = "{";  8'h5B: code = "}";  8'h4C: code = ":";  8'h41: code = "<";
            8'h49: code = ">";  8'h4A: code = "?";  8'h52: code = C_DIERESIS;
            default: ;
        endcase
        return code;
    endfunction

    function automatic logic [7:0] sc_to_extended(input logic [7:0] sc);
        logic [7:0] code;
        case (sc)
            8'h75: code = C_UP;      8'h72: code = C_DOWN;
            8'h6B: code = C_LEFT;    8'h74: code = C_RIGHT;
            8'h6C: code = C_HOME;    8'h69: code = C_END;
            8'h7D: code = C_PAGEUP;  8'h7A: code = C_PAGEDOWN;
            8'h71: code = C_DEL;     8'h5A: code = C_RETURN;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keyboard_ascii_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 input conditioning, 11-bit frame receiver and timeout.
// Revision    : 1.0
// ============================================================================
module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);
    import ps2_kbd_pkg::*;

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FCW-1:0] C_FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] C_TMO_LIMIT = TCW'(TIMEOUT_CYC);

    logic [1:0]     clk_sync_q, clk_sync_d;
    logic [1:0]     data_sync_q, data_sync_d;
    logic           filt_q, filt_d;
    logic           filt_prev_q, filt_prev_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    rx_state_t      state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           parity_q, parity_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic [7:0]     byte_q, byte_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic           w_fall;
    logic           w_data;

    assign w_fall = filt_prev_q & ~filt_q;
    assign w_data = data_sync_q[1];

    // The filtered clock only follows the synchronised input after it has
    // disagreed for FILTER_LEN consecutive samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], i_ps2_clk};
        data_sync_d = {data_sync_q[0], i_ps2_data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        filt_prev_d = filt_q;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == C_FILT_LAST) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        tmo_d     = (w_fall || state_q == RX_IDLE) ? '0 : tmo_q + 1'b1;
        if (w_fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!w_data) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shreg_d   = {w_data, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    parity_d = w_data;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (w_data && ((^shreg_q) ^ parity_q)) begin
                        valid_d = 1'b1;
                        byte_d  = shreg_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE && tmo_q >= C_TMO_LIMIT) begin
            err_d   = 1'b1;
            state_d = RX_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = valid_q;
    assign o_frame_err  = err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_ascii.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_ascii
// Description : PS/2 scan-code set 2 decoder with Shift/Caps Lock tracking.
// Revision    : 1.0
// ============================================================================
module ps2_keyboard_ascii #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       NewKey,
    output logic [7:0] Ascii,
    output logic       shift_held,
    output logic       caps_lock,
    output logic       frame_err
);
    import ps2_kbd_pkg::*;

    logic [7:0] rx_byte;
    logic       rx_valid;

    dec_state_t state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_q, caps_d;
    logic       caps_held_q, caps_held_d;
    logic       newkey_q, newkey_d;
    logic [7:0] ascii_q, ascii_d;

    logic       w_is_make;
    logic       w_is_break;
    logic       w_is_ext;
    logic       w_shift;
    logic       w_use_shift;
    logic [7:0] w_code;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (sys_clk),
        .rst          (sys_rst),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (rx_byte),
        .o_byte_valid (rx_valid),
        .o_frame_err  (frame_err)
    );

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        w_is_make  = 1'b0;
        w_is_break = 1'b0;
        w_is_ext   = 1'b0;
        if (rx_valid) begin
            case (state_q)
                DEC_NORM: begin
                    if (rx_byte == C_PFX_E0) begin
                        state_d = DEC_EXT;
                    end else if (rx_byte == C_PFX_F0) begin
                        state_d = DEC_BRK;
                    end else if (rx_byte == C_PFX_E1) begin
                        state_d = DEC_SKIP;
                        skip_d  = 3'd7;
                    end else begin
                        w_is_make = 1'b1;
                    end
                end
                DEC_EXT: begin
                    if (rx_byte == C_PFX_F0) begin
                        state_d = DEC_EXTBRK;
                    end else begin
                        w_is_make = 1'b1;
                        w_is_ext  = 1'b1;
                        state_d   = DEC_NORM;
                    end
                end
                DEC_BRK: begin
                    w_is_break = 1'b1;
                    state_d    = DEC_NORM;
                end
                DEC_EXTBRK: begin
                    w_is_break = 1'b1;
                    w_is_ext   = 1'b1;
                    state_d    = DEC_NORM;
                end
                DEC_SKIP: begin
                    // Swallows the remainder of the 8-byte Pause sequence.
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = DEC_NORM;
                    end
                end
                default: state_d = DEC_NORM;
            endcase
        end
    end

    always_comb begin
        w_shift     = lshift_q | rshift_q;
        w_use_shift = sc_is_letter(rx_byte) ? (w_shift ^ caps_q) : w_shift;
        if (w_is_ext) begin
            w_code = sc_to_extended(rx_byte);
        end else if (w_use_shift) begin
            w_code = sc_to_shifted(rx_byte);
        end else begin
            w_code = sc_to_normal(rx_byte);
        end

        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        // Extended 12/59 are the keyboard's fake shifts and are not modifiers.
        if ((w_is_make || w_is_break) && !w_is_ext) begin
            case (rx_byte)
                C_SC_LSHIFT: lshift_d = w_is_make;
                C_SC_RSHIFT: rshift_d = w_is_make;
                C_SC_CAPS: begin
                    if (w_is_make && !caps_held_q) begin
                        caps_d = ~caps_q;
                    end
                    caps_held_d = w_is_make;
                end
                default: ;
            endcase
        end

        newkey_d = w_is_make && (w_code != 8'h00);
        ascii_d  = newkey_d ? w_code : ascii_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= DEC_NORM;
            skip_q      <= 3'd0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            newkey_q    <= 1'b0;
            ascii_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            newkey_q    <= newkey_d;
            ascii_q     <= ascii_d;
        end
    end

    assign NewKey     = newkey_q;
    assign Ascii      = ascii_q;
    assign shift_held = lshift_q | rshift_q;
    assign caps_lock  = caps_q;

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_ascii.md
Name: ps2_keyboard_ascii

Overview:
- Upstream stage of the text editor: receives PS/2 scan-code set 2 frames from the keyboard and converts them to the editor's 8-bit key codes.
- Delivers each key as a one-cycle NewKey pulse with Ascii valid.
- Tracks the Shift and Caps Lock modifiers and discards break codes, frames with errors, and unsupported keys.

Parameters:
- FILTER_LEN, 8: consecutive identical sys_clk samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYC, 50000: sys_clk cycles with no ps2_clk falling edge mid-frame before the partial frame is dropped.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- ps2_clk  in  1  raw keyboard clock, asynchronous.
- ps2_data  in  1  raw keyboard data, asynchronous.
- NewKey  out  1  one-cycle pulse; Ascii is valid in that cycle.
- Ascii  out  8  key code; holds its value until the next NewKey.
- shift_held  out  1  level: left or right Shift is currently held.
- caps_lock  out  1  level: Caps Lock toggle state.
- frame_err  out  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Behaviour:
- Reset: every output is 0; receiver and decoder return to IDLE; the modifier flags and the E1 skip counter clear. A reset mid-frame drops the partial byte.
- Input conditioning: both inputs pass through 2-FF synchronisers. ps2_clk is then glitch-filtered by FILTER_LEN. A falling edge of the filtered clock is a one-cycle strobe, fall.
- Receiver FSM (sub-module):
  - IDLE: on fall with data=0 (start bit) go to DATA; on fall with data=1 stay in IDLE.
  - DATA: shift 8 bits, LSB first, one per fall, then go to PARITY.
  - PARITY: sample the bit; the frame requires odd parity over data+parity. Go to STOP.
  - STOP: requires data=1.
  - If parity and stop are both good, pulse byte_valid for one cycle in the cycle after the stop fall. Otherwise pulse frame_err and emit no byte. Either way return to IDLE.
  - A counter clears on every fall. If it reaches TIMEOUT_CYC while not in IDLE: pulse frame_err and return to IDLE.
- Decoder FSM, advances only on byte_valid:
  - NORM: E0→EXT; F0→BRK; E1→SKIP with a count of 7; any other byte is a make code.
  - EXT: F0→EXTBRK; any other byte is an extended make code, then return to NORM.
  - BRK: the byte is a break code, then NORM. EXTBRK: extended break, then NORM.
  - SKIP: decrement the count on each byte; at 0 return to NORM. This discards the Pause sequence.
- Modifiers:
  - Make of 12 or 59 sets the corresponding shift bit; break of the same code clears it. shift_held is the OR of the two bits.
  - Make of 58 toggles caps_lock only if caps_held=0, then sets caps_held; break of 58 clears caps_held. Typematic repeats therefore do not re-toggle.
  - Extended 12 and 59 (fake shifts) are ignored.
- Translation:
  - A make code is looked up in the normal, shifted or extended table.
  - Letters use shift_held XOR caps_lock; other printable keys use shift_held.
  - A nonzero result drives Ascii and pulses NewKey in the cycle after byte_valid, i.e. 2 sys_clk after the stop-bit fall strobe.
  - A result of 00 (unmapped key) produces no pulse. Break codes never pulse. Typematic repeat makes pulse again.
- Editor control codes:
  - Extended keys: 75 UP=11, 72 DOWN=12, 6B LEFT=13, 74 RIGHT=14, 6C HOME=02, 69 END=03, 7D PGUP=01, 7A PGDN=04, 71 DEL=7F, 5A keypad Enter=0D.
  - Normal control keys: 66 BS=08, 0D TAB=09, 5A RET=0D, 29 SPACE=20.
  - Function keys F1..F11 = 05,06,04,0C,03,0B,83,0A,01,09,78 map to 15..1F.
  - Dead keys: 52 maps to B4 (acute) unshifted and A8 (dieresis) shifted.
- NewKey never asserts on two consecutive cycles, because bytes arrive at most once per PS/2 frame (≥ about 0.5 ms).

Decomposition:
- Package ps2_kbd_pkg holds:
  - key-code constants (PAGEUP…F11, DEL, SPACE, TILDE, DIERESIS), shared with the editor;
  - PS/2 prefix constants E0, E1 and F0;
  - the three translation functions: normal, shifted and extended scan code → 8-bit code.
- One sub-module, ps2_rx: synchroniser, filter, frame FSM and timeout. It outputs byte, byte_valid and frame_err.
- The decoder FSM and modifier flags live in the top level.

Test Plan:
- Frame 1C ('a', parity 0 because the data holds three ones) → NewKey once, Ascii=61, 2 cycles after the stop fall; shift_held=0.
- Sequence 12, 1C, F0 1C, F0 12 → shift_held rises and falls; exactly one NewKey, with Ascii=41.
- Make 58 three times, break 58, make 58 → caps_lock=1 after the first make and unchanged through the repeats, then 0 after the second press; a following 1C gives Ascii=41 while caps_lock=1.
- Sequence E0 75, E0 F0 75, 05, F0 05 → exactly two NewKey pulses, Ascii=11 then 15.
- Frame 1C with the parity bit flipped → frame_err pulse, no NewKey. Next, 5 data bits then a silence of TIMEOUT_CYC+1 → frame_err pulse. A clean 5A afterwards → Ascii=0D.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C → no pulse for the sequence, then Ascii=61. Also assert sys_rst mid-frame → all outputs 0, and the next frame decodes correctly.
